vga_sync_gen: RTL and testbench

//   Generates 640x480@60 VGA raster timing for the Battleship display.

---
 rtl/vga_sync_gen.sv | 107 ++++++++++
 tb/tb_vga_sync_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA raster timing: pixel divider, x/y counters, sync strobes
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       vga_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_b,
  output logic       sync_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          pix_en;
  logic          line_end;
  logic          frame_end;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;

  // Composite sync is unused by this display.
  assign sync_b = 1'b0;

  // Divider next state and the pixel enable on its last count.
  always_comb begin
    pix_en  = (div_cnt == DIV_LAST);
    div_nxt = pix_en ? '0 : div_cnt + DW'(1);
  end

  // Raster position after the coming pixel step; strobes are decoded from it
  // so they line up with x/y with no extra pipeline stage.
  always_comb begin
    line_end  = (x == H_LAST);
    frame_end = line_end && (y == V_LAST);
    x_nxt     = line_end ? 10'd0 : x + 10'd1;
    y_nxt     = y;
    if (line_end) begin
      y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
  end

  // Pixel divider and vga_clk, whose rising edge lands mid-pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      vga_clk <= (div_nxt >= DIV_HALF);
    end
  end

  // Counters and strobes advance together once per pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= 10'd0;
      y       <= 10'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_b <= 1'b0;
    end else if (pix_en) begin
      x       <= x_nxt;
      y       <= y_nxt;
      hsync   <= !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
      vsync   <= !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
      blank_b <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end
  end

  // Single-clk marker on the pixel step that wraps the raster to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_end;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen against an arithmetic raster model
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;            // posedges since reset release
  int hs_low_full = 0;
  int fs_small[$];

  // full-size raster, CLK_DIV=2
  logic       vc_f, hs_f, vs_f, bb_f, sb_f, fs_f;
  logic [9:0] x_f, y_f;
  vga_sync_gen u_full (
    .clk(clk), .rst(rst), .vga_clk(vc_f), .x(x_f), .y(y_f), .hsync(hs_f),
    .vsync(vs_f), .blank_b(bb_f), .sync_b(sb_f), .frame_start(fs_f)
  );

  // reduced raster (25 x 15), CLK_DIV=2
  logic       vc_s, hs_s, vs_s, bb_s, sb_s, fs_s;
  logic [9:0] x_s, y_s;
  vga_sync_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                 .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_small (
    .clk(clk), .rst(rst), .vga_clk(vc_s), .x(x_s), .y(y_s), .hsync(hs_s),
    .vsync(vs_s), .blank_b(bb_s), .sync_b(sb_s), .frame_start(fs_s)
  );

  // reduced raster, CLK_DIV=4
  logic       vc_d, hs_d, vs_d, bb_d, sb_d, fs_d;
  logic [9:0] x_d, y_d;
  vga_sync_gen #(.CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                 .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_div4 (
    .clk(clk), .rst(rst), .vga_clk(vc_d), .x(x_d), .y(y_d), .hsync(hs_d),
    .vsync(vs_d), .blank_b(bb_d), .sync_b(sb_d), .frame_start(fs_d)
  );

  typedef struct packed {
    logic       vclk;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bb;
    logic       fs;
  } exp_t;

  // Expected outputs after kk clocks since release, from pixel arithmetic.
  function automatic exp_t model(int kk, int d, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb);
    exp_t e;
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int p  = kk / d;
    int px = p % ht;
    int py = (p / ht) % vt;
    e.vclk = ((kk % d) >= d / 2);
    e.x    = 10'(px);
    e.y    = 10'(py);
    e.hs   = !(px >= ha + hf && px < ha + hf + hs);
    e.vs   = !(py >= va + vf && py < va + vf + vs);
    e.bb   = (p > 0) && (px < ha) && (py < va);
    e.fs   = (p > 0) && ((p % (ht * vt)) == 0) && ((kk % d) == 0);
    return e;
  endfunction

  task automatic chk(string tag, logic [9:0] obs, logic [9:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, expv);
    end
  endtask

  task automatic chk_dut(string n, exp_t e, logic vc, logic [9:0] xo, logic [9:0] yo,
                         logic hs, logic vs, logic bb, logic sb, logic fs);
    chk({n, ".vga_clk"}, 10'(vc), 10'(e.vclk));
    chk({n, ".x"}, xo, e.x);
    chk({n, ".y"}, yo, e.y);
    chk({n, ".hsync"}, 10'(hs), 10'(e.hs));
    chk({n, ".vsync"}, 10'(vs), 10'(e.vs));
    chk({n, ".blank_b"}, 10'(bb), 10'(e.bb));
    chk({n, ".sync_b"}, 10'(sb), 10'd0);
    chk({n, ".frame_start"}, 10'(fs), 10'(e.fs));
  endtask

  task automatic check_all();
    chk_dut("full", model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33),
            vc_f, x_f, y_f, hs_f, vs_f, bb_f, sb_f, fs_f);
    chk_dut("small", model(k, 2, 16, 2, 4, 3, 8, 2, 2, 3),
            vc_s, x_s, y_s, hs_s, vs_s, bb_s, sb_s, fs_s);
    chk_dut("div4", model(k, 4, 16, 2, 4, 3, 8, 2, 2, 3),
            vc_d, x_d, y_d, hs_d, vs_d, bb_d, sb_d, fs_d);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    if (!hs_f) hs_low_full++;
    if (fs_s) fs_small.push_back(k);
    check_all();
  endtask

  // Assert reset between edges, check it takes effect at once, hold, release.
  task automatic async_reset(int hold);
    @(negedge clk);
    #2 rst = 1'b1;
    k = 0;
    #1 check_all();
    repeat (hold) tick();
    #2 rst = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    #2 rst = 1'b0;

    // two full lines on the big raster, several small frames
    hs_low_full = 0;
    fs_small.delete();
    repeat (3300) tick();
    chk("hsync_low_clks_2lines", 10'(hs_low_full), 10'(2 * 96 * 2));
    chk("small_fs_count", 10'(fs_small.size()), 10'd4);
    if (fs_small.size() >= 2) begin
      chk("small_fs_first", 10'(fs_small[0]), 10'd750);
      chk("small_fs_interval", 10'(fs_small[1] - fs_small[0]), 10'd750);
    end

    // reset while small raster is inside both hsync and vsync (x=19, y=10)
    async_reset(2);
    repeat (538) tick();
    chk("small_in_hsync", 10'(hs_s), 10'd0);
    chk("small_in_vsync", 10'(vs_s), 10'd0);
    async_reset(1);
    fs_small.delete();
    repeat (760) tick();
    chk("post_reset_fs_count", 10'(fs_small.size()), 10'd1);
    if (fs_small.size() >= 1) chk("post_reset_fs_at", 10'(fs_small[0]), 10'd750);

    // random run lengths and reset points
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(900, 50)) tick();
      async_reset($urandom_range(3, 1));
    end
    repeat ($urandom_range(900, 100)) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
